// File: rtl/tt_sweep_capture_if.sv
// tt_sweep_capture_if: sweep request/status, function drive/sample and truth-table bundle.
// TT_COMPARE_EN adds the expected-table compare signals.
interface tt_sweep_capture_if #(parameter int N_IN = 3);
   logic start;
   logic [N_IN-1:0] vec_out;
   logic y_in;
   logic busy;
   logic done;
   logic [2**N_IN-1:0] table_out;
`ifdef TT_COMPARE_EN
   logic [2**N_IN-1:0] expected;
   logic mismatch;
   logic [N_IN-1:0] mismatch_idx;
   modport master (output start, y_in, expected, input vec_out, busy, done, table_out, mismatch, mismatch_idx);
   modport slave (input start, y_in, expected, output vec_out, busy, done, table_out, mismatch, mismatch_idx);
`else
   modport master (output start, y_in, input vec_out, busy, done, table_out);
   modport slave (input start, y_in, output vec_out, busy, done, table_out);
`endif
endinterface

// File: rtl/tt_sweep_capture.sv
// tt_sweep_capture: sweeps a combinational block's inputs in ascending order and packs its truth table.
// TT_COMPARE_EN adds a compare of the captured table against an expected table latched at start.
module tt_sweep_capture #(
   parameter int N_IN   = 3,
   parameter int SETTLE = 1
) (
   input logic clk,
   input logic rst_n,
   tt_sweep_capture_if.slave bus
);
   localparam int W  = 2**N_IN;
   localparam int CW = $clog2(SETTLE + 1);
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
   logic [1:0] state;
   logic [CW-1:0] cnt;
   logic [N_IN-1:0] vec;
   logic [W-1:0] tbl;
   logic last_settle, last_vec;
   assign last_settle = cnt == CW'(SETTLE - 1);
   assign last_vec    = vec == {N_IN{1'b1}};
   assign bus.vec_out   = vec;
   assign bus.table_out = tbl;
   assign bus.busy      = state == RUN;
   assign bus.done      = state == DONE;
`ifdef TT_COMPARE_EN
   logic [W-1:0] exp_q, tbl_nx, diff;
   logic [N_IN-1:0] idx;
   logic mis;
   logic [N_IN-1:0] mis_idx;
   assign bus.mismatch     = mis;
   assign bus.mismatch_idx = mis_idx;
   // compare against the table as it will read after the final capture edge
   always_comb begin
      tbl_nx = tbl;
      tbl_nx[vec] = bus.y_in;
      diff = tbl_nx ^ exp_q;
      idx = '0;
      for (int i = W - 1; i >= 0; i--) if (diff[i]) idx = N_IN'(i);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q   <= '0;
         mis     <= 1'b0;
         mis_idx <= '0;
      end else if (state == IDLE && bus.start) begin
         exp_q   <= bus.expected;
         mis     <= 1'b0;
         mis_idx <= '0;
      end else if (state == RUN && last_settle && last_vec) begin
         mis     <= |diff;
         mis_idx <= idx;
      end
   end
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         vec   <= '0;
         tbl   <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               state <= RUN;
               cnt   <= '0;
               vec   <= '0;
               tbl   <= '0;
            end
            RUN: begin
               cnt <= last_settle ? '0 : cnt + 1'b1;
               if (last_settle) begin
                  tbl[vec] <= bus.y_in;
                  if (last_vec) state <= DONE;
                  else vec <= vec + 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tt_sweep_capture.sv
// tb_tt_sweep_capture: randomized and directed sweeps of two instances (SETTLE=1 and SETTLE=3).
// Set TT_COMPARE_EN to also exercise the expected-table compare.
module tb_tt_sweep_capture;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int nv = 0;
   int ne = 0;
   int mode1 = 0, mode3 = 0;
   logic [7:0] rnd1 = '0, rnd3 = '0;
   logic st1 = 1'b0, st3 = 1'b0;
   logic [2:0] tv [64];
   logic tbz [64];
   logic td [64];
   logic [7:0] ttbl;
   int tn;

   always #5 clk = ~clk;

   tt_sweep_capture_if #(.N_IN(3)) b1 ();
   tt_sweep_capture_if #(.N_IN(3)) b3 ();

   tt_sweep_capture #(.N_IN(3), .SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   tt_sweep_capture #(.N_IN(3), .SETTLE(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

   function automatic logic fn(input int m, input logic [7:0] r, input logic [2:0] v);
      logic a, b, d;
      {a, b, d} = v;
      case (m)
         0: return 1'b0;
         1: return 1'b1;
         2: return (a | b) & (~a | d);
         3: return d;
         4: return (v == 3'd5) ? 1'b0 : (a | b) & (~a | d);
         default: return r[v];
      endcase
   endfunction

   function automatic logic [2:0] exp_vec(input int k, input int s);
      return k < 8 * s ? 3'(k / s) : 3'd7;
   endfunction

   assign b1.start = st1;
   assign b3.start = st3;
   assign b1.y_in  = fn(mode1, rnd1, b1.vec_out);
   assign b3.y_in  = fn(mode3, rnd3, b3.vec_out);
`ifdef TT_COMPARE_EN
   logic [7:0] exp1 = '0;
   assign b1.expected = exp1;
   assign b3.expected = 8'h00;
`endif

   task automatic sweep(input int sel, input int s, input int p1, input int p2);
      tn = 8 * s + 4;
      @(negedge clk);
      if (sel == 3) st3 = 1'b1; else st1 = 1'b1;
      @(negedge clk);
      for (int k = 0; k < tn; k++) begin
         tv[k]  = sel == 3 ? b3.vec_out : b1.vec_out;
         tbz[k] = sel == 3 ? b3.busy : b1.busy;
         td[k]  = sel == 3 ? b3.done : b1.done;
         if (sel == 3) st3 = (k == p1 || k == p2); else st1 = (k == p1 || k == p2);
         @(negedge clk);
      end
      st1 = 1'b0;
      st3 = 1'b0;
      ttbl = sel == 3 ? b3.table_out : b1.table_out;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      nv++;
      if ({b1.vec_out, b1.busy, b1.done, b1.table_out} !== 13'h0) begin
         ne++;
         $display("FAIL reset_s1 vec=%0d busy=%b done=%b table=%h, want 0/0/0/00", b1.vec_out, b1.busy, b1.done, b1.table_out);
      end
      nv++;
      if ({b3.vec_out, b3.busy, b3.done, b3.table_out} !== 13'h0) begin
         ne++;
         $display("FAIL reset_s3 vec=%0d busy=%b done=%b table=%h, want 0/0/0/00", b3.vec_out, b3.busy, b3.done, b3.table_out);
      end
   endtask

   task automatic test_constant;
      int nb = 0;
      mode1 = 1;
      sweep(1, 1, -1, -1);
      for (int k = 0; k < tn; k++) begin
         nb += int'(tbz[k]);
         nv++;
         if (tv[k] !== exp_vec(k, 1) || tbz[k] !== (k < 8) || td[k] !== (k == 8)) begin
            ne++;
            $display("FAIL const_cycle%0d vec=%0d busy=%b done=%b, want %0d/%b/%b", k, tv[k], tbz[k], td[k], exp_vec(k, 1), k < 8, k == 8);
         end
      end
      nv++;
      if (nb != 8) begin ne++; $display("FAIL const_busy_len got %0d want 8", nb); end
      nv++;
      if (ttbl !== 8'hFF) begin ne++; $display("FAIL const_table got %h want ff", ttbl); end
   endtask

   task automatic test_function;
      mode1 = 2;
      sweep(1, 1, -1, -1);
      nv++;
      if (ttbl !== 8'hAC) begin ne++; $display("FAIL func_table got %h want ac", ttbl); end
      nv++;
      if (b1.vec_out !== 3'd7 || tv[tn-1] !== 3'd7) begin
         ne++;
         $display("FAIL func_vec_hold got %0d/%0d want 7", b1.vec_out, tv[tn-1]);
      end
   endtask

   task automatic test_settle_ignore;
      int nb = 0, nd = 0;
      mode3 = 3;
      sweep(3, 3, 5, 24);
      for (int k = 0; k < tn; k++) begin
         nb += int'(tbz[k]);
         nd += int'(td[k]);
         nv++;
         if (tv[k] !== exp_vec(k, 3) || tbz[k] !== (k < 24) || td[k] !== (k == 24)) begin
            ne++;
            $display("FAIL settle_cycle%0d vec=%0d busy=%b done=%b, want %0d/%b/%b", k, tv[k], tbz[k], td[k], exp_vec(k, 3), k < 24, k == 24);
         end
      end
      nv++;
      if (nb != 24 || nd != 1) begin ne++; $display("FAIL settle_counts busy=%0d done=%0d want 24/1", nb, nd); end
      nv++;
      if (ttbl !== 8'hAA) begin ne++; $display("FAIL settle_table got %h want aa", ttbl); end
   endtask

   task automatic test_reset_mid;
      int w = 0;
      int nd = 0;
      mode1 = 1;
      @(negedge clk); st1 = 1'b1;
      @(negedge clk); st1 = 1'b0;
      while (b1.vec_out !== 3'd4 && w < 40) begin @(negedge clk); w++; end
      nv++;
      if (w >= 40) begin ne++; $display("FAIL rstmid_reach_vec4 got vec=%0d want 4", b1.vec_out); end
      #2 rst_n = 1'b0;
      #1;
      nv++;
      if ({b1.vec_out, b1.busy, b1.done, b1.table_out} !== 13'h0) begin
         ne++;
         $display("FAIL rstmid_abort vec=%0d busy=%b done=%b table=%h, want 0/0/0/00", b1.vec_out, b1.busy, b1.done, b1.table_out);
      end
      repeat (2) begin @(negedge clk); nd += int'(b1.done); end
      rst_n = 1'b1;
      repeat (4) begin @(negedge clk); nd += int'(b1.done) + int'(b1.busy); end
      nv++;
      if (nd != 0) begin ne++; $display("FAIL rstmid_no_done got %0d done/busy cycles want 0", nd); end
      mode1 = 0;
      sweep(1, 1, -1, -1);
      nv++;
      if (ttbl !== 8'h00 || td[8] !== 1'b1) begin ne++; $display("FAIL rstmid_resweep table=%h done8=%b want 00/1", ttbl, td[8]); end
   endtask

   task automatic test_random;
      for (int r = 0; r < 8; r++) begin
         int sel, s;
         logic [7:0] want;
         sel = (r % 2 == 0) ? 1 : 3;
         s = sel == 3 ? 3 : 1;
         want = 8'($urandom);
         if (sel == 3) begin rnd3 = want; mode3 = 5; end else begin rnd1 = want; mode1 = 5; end
         repeat ($urandom_range(0, 3)) @(negedge clk);
         sweep(sel, s, int'($urandom_range(0, 8 * s)), -1);
         nv++;
         if (ttbl !== want) begin ne++; $display("FAIL random%0d_table got %h want %h", r, ttbl, want); end
         nv++;
         if (td[8 * s] !== 1'b1 || tbz[8 * s - 1] !== 1'b1 || tbz[8 * s] !== 1'b0) begin
            ne++;
            $display("FAIL random%0d_timing done=%b busy_last=%b busy_after=%b want 1/1/0", r, td[8 * s], tbz[8 * s - 1], tbz[8 * s]);
         end
      end
   endtask

`ifdef TT_COMPARE_EN
   task automatic test_compare;
      exp1 = 8'hAC;
      mode1 = 4;
      sweep(1, 1, -1, -1);
      nv++;
      if (ttbl !== 8'h8C || b1.mismatch !== 1'b1 || b1.mismatch_idx !== 3'd5) begin
         ne++;
         $display("FAIL compare_bad table=%h mis=%b idx=%0d want 8c/1/5", ttbl, b1.mismatch, b1.mismatch_idx);
      end
      mode1 = 2;
      sweep(1, 1, -1, -1);
      nv++;
      if (ttbl !== 8'hAC || b1.mismatch !== 1'b0 || b1.mismatch_idx !== 3'd0) begin
         ne++;
         $display("FAIL compare_good table=%h mis=%b idx=%0d want ac/0/0", ttbl, b1.mismatch, b1.mismatch_idx);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_constant();
      test_function();
      test_settle_ignore();
      test_reset_mid();
      test_random();
`ifdef TT_COMPARE_EN
      test_compare();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nv, ne);
      $finish;
   end
endmodule

// File: doc/tt_sweep_capture.md
Name: tt_sweep_capture

Overview:
- Sequencing stage wrapped around a small combinational function block, such as the 3-input POS/SOP function under test.
- Upstream role: drives the function's inputs through every combination in ascending binary order.
- Downstream role: samples the function output for each combination and assembles a packed truth table.
- Used for on-chip self-check of combinational blocks without a testbench loop.

Parameters:
- N_IN, 3, number of function inputs; truth table width is 2**N_IN. Legal range 1..6.
- SETTLE, 1, clock cycles each input vector is held before y_in is sampled. Legal values >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a sweep; accepted only in IDLE.
- vec_out  output  N_IN  drives the function inputs; MSB is the first input. For N_IN=3: [2]=a, [1]=b, [0]=d.
- y_in  input  1  function output, sampled synchronously.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when the table is complete.
- table_out  output  2**N_IN  bit i = y_in sampled while vec_out == i.

Behaviour:
- Reset (async assert, sync release on clk) forces: state=IDLE, vec_out=0, busy=0, done=0, table_out=0, settle counter=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> RUN on the next edge.
  - That edge clears table_out to 0, sets vec_out=0 and settle counter=0.
  - busy goes high in the same cycle RUN is entered.
- RUN:
  - The settle counter increments every cycle.
  - On the edge where counter == SETTLE-1, table_out[vec_out] <= y_in.
  - At that same edge: if vec_out == 2**N_IN-1, go to DONE; otherwise vec_out <= vec_out+1 and counter <= 0.
  - Each vector is held exactly SETTLE cycles.
  - busy stays high for exactly (2**N_IN)*SETTLE cycles.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then return to IDLE.
  - vec_out holds at 2**N_IN-1 after the sweep until the next accepted start.
  - table_out holds its value until the next accepted start or reset.
- start while in RUN or DONE is ignored; no queuing.
- start must be re-asserted in IDLE to begin a new sweep.
- Latency from the start edge to the done pulse: (2**N_IN)*SETTLE + 1 cycles.
- y_in is treated as combinational from vec_out. No sampling occurs outside the counter == SETTLE-1 cycle.
- Reset asserted mid-sweep:
  - Immediate abort; all outputs take reset values.
  - No done pulse.
  - A partial table is not retained.
- vec_out counter width is N_IN. The final increment is suppressed, so there is no wrap.

Optional Feature:
- Macro: TT_COMPARE_EN.
- Defined:
  - Adds input expected[2**N_IN-1:0], latched when start is accepted.
  - Adds outputs mismatch (1 bit) and mismatch_idx (N_IN bits), both updated on the edge that enters DONE and held until the next accepted start or reset.
  - mismatch = (table_out != latched expected).
  - mismatch_idx = lowest index i where they differ; 0 if no difference.
  - Reset values: mismatch=0, mismatch_idx=0.
- Undefined: ports and compare logic are absent; all other behaviour is identical.

Test Plan:
1. Reset value, SETTLE=1, N_IN=3:
   - Stimulus: apply rst_n=0, then release, with no start.
   - Required response: vec_out=0, busy=0, done=0, table_out=8'h00.
2. Constant output, SETTLE=1:
   - Stimulus: y_in tied 1, one start pulse.
   - Required response: busy high exactly 8 cycles; vec_out steps 0..7 one per cycle; done pulse on cycle 9 after the start edge; table_out=8'hFF.
3. Function sweep:
   - Stimulus: y_in=(a|b)&(~a|d) modelled from vec_out; start pulse.
   - Required response: table_out=8'hAC; vec_out holds 7 after done.
4. Settle and start-ignore, SETTLE=3:
   - Stimulus: y_in=d; start pulses again at cycles 5 and 24 of the sweep.
   - Required response: each vector held 3 cycles; busy 24 cycles; exactly one done pulse; table_out=8'hAA.
5. Reset mid-sweep:
   - Stimulus: assert rst_n=0 when vec_out=4, then release and start a new sweep with y_in=0.
   - Required response: immediate busy=0, table_out=0, no done pulse; the new sweep completes with table_out=8'h00.
6. Compare (TT_COMPARE_EN defined):
   - Stimulus: expected=8'hAC, function from scenario 3 with vec 5 forced low.
   - Required response: table_out=8'h8C, mismatch=1, mismatch_idx=5; a rerun with the correct function gives mismatch=0.
